// File: rtl/offset_pkg.sv
// Shared types and constants for the branch offset splitter.
// Optional hop index output is enabled by BRANCH_OFFSET_SPLITTER_HOP_IDX_EN.
package offset_pkg;

    localparam int unsigned IN_W     = 8;
    localparam int unsigned OFF_W    = 4;
    localparam int unsigned R_W      = IN_W + 1;
    localparam int unsigned MAX_HOPS = 19;
    localparam int unsigned HOP_W    = $clog2(MAX_HOPS);

    localparam int OFF_MIN = -(2 ** (OFF_W - 1));
    localparam int OFF_MAX = (2 ** (OFF_W - 1)) - 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } split_state_t;

endpackage

// File: rtl/branch_offset_splitter_if.sv
// Displacement-in / offset-chunk-out bus; hop_idx exists only with
// BRANCH_OFFSET_SPLITTER_HOP_IDX_EN defined.
interface branch_offset_splitter_if;
    import offset_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_disp;
    logic                    in_br;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OFF_W-1:0] out_off;
    logic                    out_br;
    logic                    out_last;
    logic                    err;
`ifdef BRANCH_OFFSET_SPLITTER_HOP_IDX_EN
    logic [HOP_W-1:0]        hop_idx;

    modport slave (
        input  in_valid, in_disp, in_br, out_ready,
        output in_ready, out_valid, out_off, out_br, out_last, err, hop_idx
    );
    modport master (
        output in_valid, in_disp, in_br, out_ready,
        input  in_ready, out_valid, out_off, out_br, out_last, err, hop_idx
    );
`else
    modport slave (
        input  in_valid, in_disp, in_br, out_ready,
        output in_ready, out_valid, out_off, out_br, out_last, err
    );
    modport master (
        output in_valid, in_disp, in_br, out_ready,
        input  in_ready, out_valid, out_off, out_br, out_last, err
    );
`endif

endinterface

// File: rtl/offset_clamp.sv
// Clamps a full-width residual to the offset field range and flags whether
// it already fits.
module offset_clamp
    import offset_pkg::*;
(
    input  logic signed [R_W-1:0]   r,
    output logic signed [OFF_W-1:0] chunk,
    output logic                    in_range
);

    localparam logic signed [R_W-1:0] MIN_R = R_W'(OFF_MIN);
    localparam logic signed [R_W-1:0] MAX_R = R_W'(OFF_MAX);

    // Compare at full width before truncating to the field.
    always_comb begin
        chunk    = OFF_W'(r);
        in_range = 1'b1;
        if (r < MIN_R) begin
            chunk    = OFF_W'(MIN_R);
            in_range = 1'b0;
        end else if (r > MAX_R) begin
            chunk    = OFF_W'(MAX_R);
            in_range = 1'b0;
        end
    end

endmodule

// File: rtl/branch_offset_splitter.sv
// Splits a signed displacement into a run of narrow signed offset chunks.
// Define BRANCH_OFFSET_SPLITTER_HOP_IDX_EN to add the hop_idx output.
module branch_offset_splitter
    import offset_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    branch_offset_splitter_if.slave  bus
);

    split_state_t            state_q, state_d;
    logic signed [R_W-1:0]   r_q, r_d, clamp_in;
    logic signed [OFF_W-1:0] off_q, off_d, chunk;
    logic                    in_range;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    last_q, last_d;
    logic                    br_q, br_d;
    logic                    err_q, err_d;
`ifdef BRANCH_OFFSET_SPLITTER_HOP_IDX_EN
    logic [HOP_W-1:0]        hop_q, hop_d;
`endif

    // One clamp serves both the IDLE range check and the next EMIT chunk.
    assign clamp_in = (state_q == IDLE) ? R_W'(bus.in_disp) : R_W'(r_q - R_W'(off_q));

    offset_clamp u_clamp (
        .r        (clamp_in),
        .chunk    (chunk),
        .in_range (in_range)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            off_q       <= '0;
            last_q      <= 1'b0;
            br_q        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_q       <= 1'b0;
`ifdef BRANCH_OFFSET_SPLITTER_HOP_IDX_EN
            hop_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            off_q       <= off_d;
            last_q      <= last_d;
            br_q        <= br_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            err_q       <= err_d;
`ifdef BRANCH_OFFSET_SPLITTER_HOP_IDX_EN
            hop_q       <= hop_d;
`endif
        end
    end

    // Next state plus next registered outputs, so every output is a flop.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        off_d       = off_q;
        last_d      = last_q;
        br_d        = br_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
`ifdef BRANCH_OFFSET_SPLITTER_HOP_IDX_EN
        hop_d       = hop_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_br || in_range) begin
                        state_d     = EMIT;
                        r_d         = clamp_in;
                        off_d       = chunk;
                        last_d      = in_range;
                        br_d        = bus.in_br;
                        out_valid_d = 1'b1;
`ifdef BRANCH_OFFSET_SPLITTER_HOP_IDX_EN
                        hop_d       = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
`ifdef BRANCH_OFFSET_SPLITTER_HOP_IDX_EN
                    hop_d = hop_q + HOP_W'(1);
`endif
                    if (last_q) begin
                        state_d     = IDLE;
                        r_d         = '0;
                        off_d       = '0;
                        last_d      = 1'b0;
                        br_d        = 1'b0;
                        out_valid_d = 1'b0;
                    end else begin
                        r_d    = clamp_in;
                        off_d  = chunk;
                        last_d = in_range;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_off   = off_q;
    assign bus.out_br    = br_q;
    assign bus.out_last  = last_q;
    assign bus.err       = err_q;
`ifdef BRANCH_OFFSET_SPLITTER_HOP_IDX_EN
    assign bus.hop_idx   = hop_q;
`endif

endmodule

// File: doc/branch_offset_splitter.md
# branch_offset_splitter

Narrowing counterpart to `sign_extension`: accepts an 8-bit signed displacement and emits it as a sequence of 4-bit signed offset fields. Each field, when sign-extended downstream, sums back to the original displacement. Sits between the branch/address computation stage and the instruction-field writer. Branch displacements wider than the 4-bit field are split into multiple hops; out-of-range data offsets are rejected.

## Interface
- `IN_W`, 8, displacement width (two's complement)
- `OFF_W`, 4, emitted offset field width (two's complement)
- `clk` in 1, single clock, rising edge
- `reset_n` in 1, asynchronous active-low reset
- `in_valid` in 1, displacement offered
- `in_ready` out 1, block can accept; high only in IDLE
- `in_disp` in IN_W, signed displacement
- `in_br` in 1, 1 = branch (splitting allowed), 0 = data offset (must fit in one field)
- `out_valid` out 1, offset field valid
- `out_ready` in 1, consumer accepts field
- `out_off` out OFF_W, signed offset chunk
- `out_br` out 1, copy of the accepted `in_br`
- `out_last` out 1, final chunk of the current displacement
- `err` out 1, one-cycle pulse: data offset out of range, dropped

## Operation
- States: IDLE and EMIT.
- IDLE: `in_ready`=1. On `in_valid`:
  - If `in_br`=1, or `in_disp` is within [-8, 7]: latch residual R = `in_disp` and br, then go to EMIT.
  - Else (`in_br`=0 and out of range): pulse `err` next cycle, stay in IDLE, emit nothing.
- EMIT: `out_valid`=1.
  - `out_off` = clamp(R, -8, 7).
  - `out_last` = 1 iff R is within [-8, 7].
  - On `out_valid && out_ready`: R <= R − `out_off`. If `out_last`, go to IDLE; otherwise stay in EMIT.
- Arithmetic: R is held at IN_W+1 bits; subtraction never overflows. The clamp compares R in full width before truncating to OFF_W.
- Zero displacement emits exactly one chunk, `out_off`=0, `out_last`=1.
- Hop counts: -128 needs 16 chunks of -8; +127 needs 18 chunks of 7 followed by 1. Maximum is 19 chunks.
- `in_valid` while in EMIT is ignored (not accepted).

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_off`=0, `out_br`=0, `out_last`=0, `err`=0. R=0, state IDLE.
- Input accepted at edge N → `out_valid` high from cycle N+1.
- Throughput: one chunk per cycle while `out_ready`=1.
- After the last handshake at edge M, `in_ready`=1 from cycle M+1. There is no same-cycle turnaround.
- `out_off`, `out_br`, `out_last` are stable while `out_valid && !out_ready`.
- `err` is high for exactly the cycle after the rejected input edge. `in_ready` stays 1 during that cycle.
- A `reset_n` assertion mid-transfer returns all outputs to their reset values immediately, regardless of clock. The partial transfer is discarded.

## Configuration
- `BRANCH_OFFSET_SPLITTER_HOP_IDX_EN`
  - Defined: adds output `hop_idx` [4:0]. It is 0 on the first chunk of each transfer and increments on every handshake. Reset value 0. It is stable under backpressure.
  - Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package `offset_pkg` holds:
  - `OFF_MIN` (-8) and `OFF_MAX` (7), derived from OFF_W
  - state enum `split_state_t` {IDLE, EMIT}
  - `MAX_HOPS` (19)
- One sub-module, `offset_clamp`, purely combinational: input R, outputs the clamped chunk and the in-range flag. It is shared by the IDLE range check and the EMIT chunk generation.

## Test plan
- Single chunk: `in_disp`=5, `in_br`=1, `out_ready`=1 → one beat, `out_off`=4'b0101, `out_last`=1, `out_br`=1. `in_ready` high again 2 cycles after accept.
- Positive split: `in_disp`=20, `in_br`=1 → beats 7, 7, 6. `out_last` only on the third. Sign-extended chunks sum to 20.
- Negative extreme: `in_disp`=-128 (8'h80), `in_br`=1 → 16 beats of 4'b1000, last flagged on the 16th. `hop_idx` reaches 15 when the macro is enabled.
- Rejection: `in_disp`=20, `in_br`=0 → `err` high for 1 cycle, `out_valid` never asserts. `in_disp`=-8, `in_br`=0 → one beat 4'b1000, `out_last`=1.
- Backpressure: `in_disp`=12, `in_br`=1, `out_ready` low for 3 cycles → `out_off`=7 held for 3 cycles, then 7 then 5 on release. An `in_valid` pulse during EMIT is not accepted.
- Reset mid-op: `in_disp`=100, drop `reset_n` after 3 chunks → `out_valid`=0 and `in_ready`=1 immediately. A new `in_disp`=0 then yields one beat `out_off`=0, `out_last`=1.
